hwpe_ctrl_job_offloader: RTL and testbench

Bus-initiator counterpart of the HWPE control register file. It accepts a job descriptor from a local master (core-side sequencer or DMA), and drives the HWPE peripheral target port to run the job: acquire a job slot, write the IO parameter registers, trigger, then wait for completion. It reports completion with the job ID. It sits between a cluster-side controller and one HWPE's peripheral slave port.

---
 rtl/hwpe_ctrl_job_offloader_pkg.sv | 34 +++
 rtl/hwpe_ctrl_job_offloader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_hwpe_ctrl_job_offloader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_ctrl_job_offloader_pkg.sv
// Shared definitions for the HWPE job offloader: register map, ACQUIRE failure codes, FSM states.
// HWPE_CTRL_OFFLOADER_POLL_EN adds the STATUS polling states.
package hwpe_ctrl_job_offloader_pkg;

  localparam logic [31:0] REG_TRIGGER = 32'h0000_0000;
  localparam logic [31:0] REG_ACQUIRE = 32'h0000_0004;
  localparam logic [31:0] REG_STATUS  = 32'h0000_000C;
  localparam logic [31:0] REG_IO_BASE = 32'h0000_0040;

  localparam logic [31:0] ACQ_ALL_BUSY     = 32'hFFFF_FFFF;
  localparam logic [31:0] ACQ_OTHER_OFFLOAD = 32'hFFFF_FFFE;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ACQ      = 4'd1,
    ST_ACQ_RSP  = 4'd2,
    ST_BACKOFF  = 4'd3,
    ST_WR       = 4'd4,
    ST_WR_RSP   = 4'd5,
    ST_TRIG     = 4'd6,
    ST_TRIG_RSP = 4'd7,
    ST_WAIT     = 4'd8
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    ,
    ST_POLL     = 4'd9,
    ST_POLL_RSP = 4'd10
`endif
  } offl_state_e;

  function automatic logic acquire_failed(input logic [31:0] rdata);
    return (rdata == ACQ_ALL_BUSY) || (rdata == ACQ_OTHER_OFFLOAD);
  endfunction

endpackage

// File: rtl/hwpe_ctrl_job_offloader.sv
// Drives an HWPE peripheral port through acquire / IO writes / trigger / completion for one job.
// Define HWPE_CTRL_OFFLOADER_POLL_EN to also detect completion by polling STATUS.
module hwpe_ctrl_job_offloader
  import hwpe_ctrl_job_offloader_pkg::*;
#(
  parameter int unsigned         N_IO_REGS      = 2,
  parameter int unsigned         ID_WIDTH       = 16,
  parameter logic [31:0]         BASE_ADDR      = 32'h0,
  parameter int unsigned         BACKOFF_CYCLES = 8,
  parameter int unsigned         MAX_RETRIES    = 16,
  parameter logic [ID_WIDTH-1:0] MY_ID          = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [N_IO_REGS*32-1:0]   job_params_i,
  output logic                      done_valid_o,
  output logic [7:0]                done_job_id_o,
  output logic                      err_o,
  output logic                      busy_o,
  input  logic                      evt_i,
  output logic                      periph_req_o,
  input  logic                      periph_gnt_i,
  output logic [31:0]               periph_add_o,
  output logic                      periph_wen_o,
  output logic [3:0]                periph_be_o,
  output logic [31:0]               periph_data_o,
  output logic [ID_WIDTH-1:0]       periph_id_o,
  input  logic                      periph_r_valid_i,
  input  logic [31:0]               periph_r_data_i,
  input  logic [ID_WIDTH-1:0]       periph_r_id_i
);

  localparam int unsigned KW      = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
  localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);
  localparam int unsigned CNT_TOP = (BACKOFF_CYCLES > 4) ? BACKOFF_CYCLES : 4;
  localparam int unsigned CW      = $clog2(CNT_TOP + 1);
  localparam int unsigned PW      = N_IO_REGS * 32;

  offl_state_e   state_q, state_d;
  logic          req_q, req_d, wen_q, wen_d;
  logic [31:0]   add_q, add_d, wdata_q, wdata_d;
  logic          ready_q, ready_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [7:0]    done_id_q, done_id_d, job_id_q, job_id_d;
  logic [PW-1:0] params_q, params_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic          evt_flag_q, evt_flag_d;
  logic          unused_rid;

  assign unused_rid = ^periph_r_id_i;
  assign retry_inc  = retry_q + RW'(1);

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      wen_q      <= 1'b0;
      add_q      <= 32'h0;
      wdata_q    <= 32'h0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_id_q  <= 8'h0;
      job_id_q   <= 8'h0;
      params_q   <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      evt_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wen_q      <= wen_d;
      add_q      <= add_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_id_q  <= done_id_d;
      job_id_q   <= job_id_d;
      params_q   <= params_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      evt_flag_q <= evt_flag_d;
    end
  end

  // Next-state and next-output logic; request states raise req one cycle after entry.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wen_d      = wen_q;
    add_d      = add_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    done_id_d  = done_id_q;
    job_id_d   = job_id_q;
    params_d   = params_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    evt_flag_d = evt_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (job_valid_i && ready_q) begin
          params_d = job_params_i;
          retry_d  = '0;
          state_d  = ST_ACQ;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_ACQ: begin
        if (!req_q) begin
          req_d   = 1'b1;
          wen_d   = 1'b1;
          add_d   = BASE_ADDR + REG_ACQUIRE;
          wdata_d = 32'h0;
        end else if (periph_gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_ACQ_RSP;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_ACQ_RSP: begin
        if (!periph_r_valid_i) begin
          state_d = ST_ACQ_RSP;
        end else if (acquire_failed(periph_r_data_i)) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          if (retry_inc == RW'(MAX_RETRIES)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BACKOFF;
          end
        end else begin
          job_id_d = periph_r_data_i[7:0];
          k_d      = '0;
          state_d  = ST_WR;
        end
      end
      ST_BACKOFF: begin
        if (cnt_q == CW'(BACKOFF_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_ACQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR: begin
        if (!req_q) begin
          req_d   = 1'b1;
          wen_d   = 1'b0;
          add_d   = BASE_ADDR + REG_IO_BASE + (32'(k_q) << 2);
          wdata_d = params_q[{k_q, 5'd0} +: 32];
        end else if (periph_gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_WR_RSP;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_WR_RSP: begin
        if (!periph_r_valid_i) begin
          state_d = ST_WR_RSP;
        end else if (k_q == KW'(N_IO_REGS - 1)) begin
          state_d = ST_TRIG;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_WR;
        end
      end
      ST_TRIG: begin
        evt_flag_d = evt_flag_q | evt_i;
        if (!req_q) begin
          req_d   = 1'b1;
          wen_d   = 1'b0;
          add_d   = BASE_ADDR + REG_TRIGGER;
          wdata_d = 32'h0;
        end else if (periph_gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_TRIG_RSP;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_TRIG_RSP: begin
        // Any event before the trigger is acknowledged belongs to an earlier job.
        if (periph_r_valid_i) begin
          evt_flag_d = evt_i;
          cnt_d      = '0;
          state_d    = ST_WAIT;
        end else begin
          evt_flag_d = evt_flag_q | evt_i;
        end
      end
      ST_WAIT: begin
        if (evt_flag_q || evt_i) begin
          evt_flag_d = 1'b1;
          done_d     = 1'b1;
          done_id_d  = job_id_q;
          state_d    = ST_IDLE;
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
        end else if (cnt_q == CW'(3)) begin
          cnt_d   = '0;
          state_d = ST_POLL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_POLL: begin
        evt_flag_d = evt_flag_q | evt_i;
        if (!req_q) begin
          req_d   = 1'b1;
          wen_d   = 1'b1;
          add_d   = BASE_ADDR + REG_STATUS;
          wdata_d = 32'h0;
        end else if (periph_gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_POLL_RSP;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_POLL_RSP: begin
        evt_flag_d = evt_flag_q | evt_i;
        if (!periph_r_valid_i) begin
          state_d = ST_POLL_RSP;
        end else if ((periph_r_data_i == 32'h0) || evt_flag_q || evt_i) begin
          done_d    = 1'b1;
          done_id_d = job_id_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
`else
        end else begin
          state_d = ST_WAIT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign job_ready_o   = ready_q;
  assign done_valid_o  = done_q;
  assign done_job_id_o = done_id_q;
  assign err_o         = err_q;
  assign busy_o        = busy_q;
  assign periph_req_o  = req_q;
  assign periph_add_o  = add_q;
  assign periph_wen_o  = wen_q;
  assign periph_be_o   = 4'hF;
  assign periph_data_o = wdata_q;
  assign periph_id_o   = MY_ID;

endmodule

// File: tb/tb_hwpe_ctrl_job_offloader.sv
// Self-checking bench for hwpe_ctrl_job_offloader: job table plus bus-transaction scoreboard.
// Build with HWPE_CTRL_OFFLOADER_POLL_EN to include the STATUS polling sequence.
module tb_hwpe_ctrl_job_offloader;

  localparam int          NIO     = 2;
  localparam int          BACKOFF = 8;
  localparam int          MAXR    = 3;
  localparam logic [31:0] BASE    = 32'h1A10_0000;
  localparam logic [15:0] MYID    = 16'h00A5;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gwait;
    int          rwait;
    bit          early_rv;
    bit          evt;
    bit          do_rsp;
    bit          retry;
  } txn_t;

  typedef struct {
    logic [31:0] p0;
    logic [31:0] p1;
    int          fails;
    logic [31:0] acq_rsp;
    int          gwait;
    int          rwait;
    int          evt_dly;
    bit          evt_on_trig;
    bit          early_rv;
    int          poll_zero_at;
    bit          check_lat;
    bit          exp_err;
    logic [7:0]  exp_id;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_i, job_valid_i, job_ready_o, done_valid_o, err_o, busy_o, evt_i;
  logic [NIO*32-1:0] job_params_i;
  logic [7:0]        done_job_id_o;
  logic              periph_req_o, periph_gnt_i, periph_wen_o, periph_r_valid_i;
  logic [31:0]       periph_add_o, periph_data_o, periph_r_data_i;
  logic [3:0]        periph_be_o;
  logic [15:0]       periph_id_o, periph_r_id_i;

  always #5 clk = ~clk;

  hwpe_ctrl_job_offloader #(
    .N_IO_REGS(NIO), .ID_WIDTH(16), .BASE_ADDR(BASE),
    .BACKOFF_CYCLES(BACKOFF), .MAX_RETRIES(MAXR), .MY_ID(MYID)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_params_i(job_params_i), .done_valid_o(done_valid_o), .done_job_id_o(done_job_id_o),
    .err_o(err_o), .busy_o(busy_o), .evt_i(evt_i),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
    .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
    .periph_id_o(periph_id_o), .periph_r_valid_i(periph_r_valid_i),
    .periph_r_data_i(periph_r_data_i), .periph_r_id_i(periph_r_id_i)
  );

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  txn_t exp_q[$];
  int   last_req_cyc = 0;
  int   prev_gr = 0;
  int   rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [31:0] rd, input int gw, input int rw,
                              input bit erv, input bit ev, input bit rsp, input bit rt);
    txn_t t;
    t.addr = a; t.wen = w; t.wdata = wd; t.rdata = rd; t.gwait = gw; t.rwait = rw;
    t.early_rv = erv; t.evt = ev; t.do_rsp = rsp; t.retry = rt;
    return t;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(periph_req_o), 32'd0);
    check({tag, "_add"},   periph_add_o, 32'd0);
    check({tag, "_wen"},   32'(periph_wen_o), 32'd0);
    check({tag, "_data"},  periph_data_o, 32'd0);
    check({tag, "_be"},    32'(periph_be_o), 32'hF);
    check({tag, "_id"},    32'(periph_id_o), 32'(MYID));
    check({tag, "_ready"}, 32'(job_ready_o), 32'd0);
    check({tag, "_done"},  32'(done_valid_o), 32'd0);
    check({tag, "_jobid"}, 32'(done_job_id_o), 32'd0);
    check({tag, "_err"},   32'(err_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
  endtask

  // Serve one DUT request: pop the expected transaction, compare, grant, respond.
  task automatic serve(output bit ok);
    txn_t        e;
    int          w;
    logic [31:0] a, d;
    logic        wn;
    bit          stable, dup;
    ok = 1'b0;
    w = 0;
    while (!periph_req_o && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!periph_req_o) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: got no request, expected one within 64 cycles");
      return;
    end
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL unexpected_req: got request to 0x%08h, expected none", periph_add_o);
      return;
    end
    e = exp_q.pop_front();
    check("addr", periph_add_o, e.addr);
    check("wen", 32'(periph_wen_o), 32'(e.wen));
    if (!e.wen) check("wdata", periph_data_o, e.wdata);
    if (e.retry) check("backoff_gap", 32'(cyc - last_req_cyc), 32'(BACKOFF + 3 + prev_gr));
    last_req_cyc = cyc;
    prev_gr = e.gwait + e.rwait;
    a = periph_add_o; d = periph_data_o; wn = periph_wen_o; stable = 1'b1;
    repeat (e.gwait) begin
      @(negedge clk);
      if (!periph_req_o || periph_add_o !== a || periph_data_o !== d || periph_wen_o !== wn)
        stable = 1'b0;
    end
    if (e.gwait > 0) check("hold_stable", 32'(stable), 32'd1);
    periph_gnt_i = 1'b1;
    if (e.early_rv) begin
      periph_r_valid_i = 1'b1;
      periph_r_data_i  = 32'h0000_0033;
    end
    @(negedge clk);
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0; periph_r_data_i = 32'h0;
    check("req_drop", 32'(periph_req_o), 32'd0);
    ok = 1'b1;
    if (!e.do_rsp) return;
    dup = 1'b0;
    repeat (e.rwait) begin
      @(negedge clk);
      if (periph_req_o) dup = 1'b1;
    end
    if (e.rwait > 0) check("no_dup_req", 32'(dup), 32'd0);
    periph_r_valid_i = 1'b1; periph_r_data_i = e.rdata; evt_i = e.evt;
    rsp_cyc = cyc;
    @(negedge clk);
    periph_r_valid_i = 1'b0; periph_r_data_i = 32'h0; evt_i = 1'b0;
  endtask

  task automatic push_job(input vec_t v);
    int nf;
    nf = (v.fails >= MAXR) ? MAXR : v.fails;
    for (int i = 0; i < nf; i++)
      exp_q.push_back(mk(BASE + 32'h4, 1'b1, 32'h0, (i % 2 == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF,
                         v.gwait, v.rwait, 1'b0, 1'b0, 1'b1, i > 0));
    if (v.fails < MAXR) begin
      exp_q.push_back(mk(BASE + 32'h4, 1'b1, 32'h0, v.acq_rsp, v.gwait, v.rwait,
                         v.early_rv, 1'b0, 1'b1, nf > 0));
      exp_q.push_back(mk(BASE + 32'h40, 1'b0, v.p0, 32'h0, v.gwait, v.rwait, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(BASE + 32'h44, 1'b0, v.p1, 32'h0, v.gwait, v.rwait, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(BASE + 32'h0, 1'b0, 32'h0, 32'h0, v.gwait, v.rwait,
                         1'b0, v.evt_on_trig, 1'b1, 1'b0));
    end
  endtask

  task automatic start_job(input logic [31:0] p0, input logic [31:0] p1, output bit ok, output int acc);
    int w;
    w = 0;
    while (!job_ready_o && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("job_ready", 32'(job_ready_o), 32'd1);
    ok = job_ready_o;
    acc = cyc;
    if (!ok) return;
    job_params_i = {p1, p0};
    job_valid_i  = 1'b1;
    @(negedge clk);
    job_valid_i = 1'b0;
    check("busy_after_accept", 32'(busy_o), 32'd1);
    check("ready_drop", 32'(job_ready_o), 32'd0);
  endtask

  task automatic run_job(input vec_t v, output int nreads);
    bit          ok, evt_sent, zero_given, got_done, got_err;
    int          acc, t;
    logic [7:0]  gid;
    logic [31:0] rd;
    nreads = 0;
    push_job(v);
    start_job(v.p0, v.p1, ok, acc);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    while (exp_q.size() > 0 && ok) serve(ok);
    if (v.check_lat) check("job_latency", 32'(rsp_cyc - acc), 32'(3 * (NIO + 2)));
    t = 0; evt_sent = 1'b0; zero_given = 1'b0;
    while (!done_valid_o && !err_o && t < 400 && ok) begin
      if (periph_req_o) begin
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
        nreads++;
        rd = (v.poll_zero_at > 0 && nreads >= v.poll_zero_at) ? 32'h0 : 32'h1;
        if (rd == 32'h0) zero_given = 1'b1;
        exp_q.push_back(mk(BASE + 32'hC, 1'b1, 32'h0, rd, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
`else
        rd = 32'h0;
`endif
        serve(ok);
      end else begin
        evt_i = (!evt_sent && v.evt_dly >= 0 && t >= v.evt_dly);
        if (evt_i) evt_sent = 1'b1;
        @(negedge clk);
        evt_i = 1'b0;
        t++;
      end
    end
    got_done = done_valid_o; got_err = err_o; gid = done_job_id_o;
    check("done", 32'(got_done), 32'(!v.exp_err));
    check("err", 32'(got_err), 32'(v.exp_err));
    check("done_err_excl", 32'(got_done & got_err), 32'd0);
    if (!v.exp_err) check("job_id", 32'(gid), 32'(v.exp_id));
    if (got_done && !v.exp_err)
      check("done_cause", 32'(evt_sent | v.evt_on_trig | zero_given), 32'd1);
    check("txns_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    check("pulse_len", 32'({done_valid_o, err_o}), 32'd0);
    check("ready_after", 32'(job_ready_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    bit ok;
    int acc, nr;
    bit stray;

    vecs[0] = '{32'h0000_000A, 32'h0000_000B, 0, 32'h0000_0005, 0, 0, 20, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h05};
    vecs[1] = '{32'h0000_0011, 32'h0000_0022, 2, 32'h0000_0007, 0, 0, 5,  1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h07};
    vecs[2] = '{32'h0000_0033, 32'h0000_0044, 3, 32'h0000_0000, 0, 0, 5,  1'b0, 1'b0, 0, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{32'h1234_5678, 32'hDEAD_BEEF, 0, 32'h0000_01C3, 5, 2, 3,  1'b0, 1'b0, 0, 1'b0, 1'b0, 8'hC3};
    vecs[4] = '{32'h5A5A_5A5A, 32'hA5A5_A5A5, 0, 32'h0000_0042, 0, 1, -1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h42};
    vecs[5] = '{32'h0000_0001, 32'h0000_0002, 1, 32'h0000_0011, 1, 0, 10, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h11};

    rst_i = 1'b1; job_valid_i = 1'b0; job_params_i = '0; evt_i = 1'b0;
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0; periph_r_data_i = 32'h0; periph_r_id_i = 16'hBEEF;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) run_job(vecs[i], nr);

    // Reset while the first IO write is waiting for its response.
    exp_q.push_back(mk(BASE + 32'h4, 1'b1, 32'h0, 32'h0000_0009, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(BASE + 32'h40, 1'b0, 32'h0000_0077, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    start_job(32'h0000_0077, 32'h0000_0088, ok, acc);
    while (exp_q.size() > 0 && ok) serve(ok);
    exp_q.delete();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset_vals("midjob_reset");
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_valid_o || err_o || periph_req_o) stray = 1'b1;
    end
    check("no_pulse_after_reset", 32'(stray), 32'd0);
    run_job(vecs[0], nr);

`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    begin
      vec_t pv;
      pv = '{32'h0000_00C0, 32'h0000_00C1, 0, 32'h0000_0066, 0, 0, -1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h66};
      run_job(pv, nr);
      check("poll_reads", 32'(nr), 32'd2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
